// File: rtl/pkt_router_ctrl.sv
// Multi-input router controller: round-robin arbiter with optional packet lock,
// credit-based output flow control and a DELAY-deep read-latency pipeline.
module pkt_router_ctrl #(
    parameter int CLIENTS  = 4,
    parameter int WIDTH    = 32,
    parameter int DELAY    = 1,
    parameter int CREDITS  = 8,
    parameter int PKT_MODE = 1,
    parameter int IDW      = $clog2(CLIENTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CLIENTS-1:0]            empty,
    input  logic [CLIENTS-1:0]            head_eop,
    output logic [CLIENTS-1:0]            pop,
    input  logic [CLIENTS*WIDTH-1:0]      data_in,
    input  logic                          credit_return,
    output logic                          push,
    output logic [WIDTH-1:0]              data_out,
    output logic                          eop_out,
    output logic [IDW-1:0]                src_id,
    output logic [$clog2(CREDITS+1)-1:0]  credits,
    output logic                          busy,
    output logic                          cred_err
);

    localparam int CW = $clog2(CREDITS+1);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   owner;
    logic             lock;
    logic [IDW-1:0]   grant;
    logic             grant_vld;
    logic             do_pop;
    logic [IDW-1:0]   ptr_next;
    logic [CW-1:0]    cred_q;
    int unsigned      cand;

    logic [DELAY:1]   vld;
    logic [DELAY:1]   eop_q;
    logic [IDW-1:0]   idx_q [1:DELAY];

    // While locked only the owner is eligible, even when it is empty (stall).
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = 0;
        if (lock) begin
            grant     = owner;
            grant_vld = !empty[owner];
        end else begin
            for (int unsigned i = 0; i < CLIENTS; i++) begin
                cand = (int'(ptr) + i) % CLIENTS;
                if (!grant_vld && !empty[cand]) begin
                    grant     = IDW'(cand);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign do_pop   = grant_vld && (cred_q != '0) && !reset;
    assign pop      = do_pop ? (CLIENTS'(1) << grant) : '0;
    assign ptr_next = (grant == IDW'(CLIENTS-1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            owner    <= '0;
            lock     <= 1'b0;
            cred_q   <= CW'(CREDITS);
            cred_err <= 1'b0;
        end else begin
            if (do_pop) begin
                ptr <= ptr_next;
                if (PKT_MODE != 0 && !head_eop[grant]) begin
                    lock  <= 1'b1;
                    owner <= grant;
                end else begin
                    lock  <= 1'b0;
                end
            end
            case ({do_pop, credit_return})
                2'b10: cred_q <= cred_q - 1'b1;
                2'b01: begin
                    if (cred_q == CW'(CREDITS)) cred_err <= 1'b1;
                    else                        cred_q   <= cred_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld   <= '0;
            eop_q <= '0;
            for (int unsigned k = 1; k <= DELAY; k++) idx_q[k] <= '0;
        end else begin
            vld[1]   <= do_pop;
            eop_q[1] <= head_eop[grant];
            idx_q[1] <= grant;
            for (int unsigned k = 2; k <= DELAY; k++) begin
                vld[k]   <= vld[k-1];
                eop_q[k] <= eop_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

    assign push     = vld[DELAY] && !reset;
    assign src_id   = idx_q[DELAY];
    assign eop_out  = eop_q[DELAY];
    assign data_out = push ? data_in[int'(idx_q[DELAY])*WIDTH +: WIDTH] : '0;
    assign credits  = cred_q;
    assign busy     = lock | (|vld);

endmodule

// File: tb/tb_pkt_router_ctrl.sv
// Directed bench: instance A (per-word RR, DELAY=2, 4 credits) and
// instance B (packet mode, DELAY=3, 8 credits), checked with immediate assertions.
module tb_pkt_router_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] DATA = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    logic        reset_a, ret_a, push_a, eop_a, busy_a, cerr_a;
    logic [3:0]  empty_a, heop_a, pop_a;
    logic [63:0] data_a;
    logic [15:0] dout_a;
    logic [1:0]  src_a;
    logic [2:0]  cred_a;

    logic        reset_b, ret_b, push_b, eop_b, busy_b, cerr_b;
    logic [3:0]  empty_b, heop_b, pop_b;
    logic [63:0] data_b;
    logic [15:0] dout_b;
    logic [1:0]  src_b;
    logic [3:0]  cred_b;

    logic [15:0] words [4];
    logic [3:0]  wcnt;
    int          g;
    int          pk;

    pkt_router_ctrl #(.CLIENTS(4), .WIDTH(16), .DELAY(2), .CREDITS(4), .PKT_MODE(0)) dut_a (
        .clk(clk), .reset(reset_a), .empty(empty_a), .head_eop(heop_a), .pop(pop_a),
        .data_in(data_a), .credit_return(ret_a), .push(push_a), .data_out(dout_a),
        .eop_out(eop_a), .src_id(src_a), .credits(cred_a), .busy(busy_a), .cred_err(cerr_a)
    );

    pkt_router_ctrl #(.CLIENTS(4), .WIDTH(16), .DELAY(3), .CREDITS(8), .PKT_MODE(1)) dut_b (
        .clk(clk), .reset(reset_b), .empty(empty_b), .head_eop(heop_b), .pop(pop_b),
        .data_in(data_b), .credit_return(ret_b), .push(push_b), .data_out(dout_b),
        .eop_out(eop_b), .src_id(src_b), .credits(cred_b), .busy(busy_b), .cred_err(cerr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven at the negedge, checked 1ns later.
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        data_a = DATA;
        data_b = DATA;
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        reset_a = 1'b1; empty_a = 4'b0000; heop_a = 4'b1111; ret_a = 1'b0;
        reset_b = 1'b1; empty_b = 4'b1111; heop_b = 4'b1111; ret_b = 1'b0;
        repeat (2) nxt();
        #1;
        chk("a_rst_pop",   pop_a,  0);
        chk("a_rst_push",  push_a, 0);
        chk("a_rst_dout",  dout_a, 0);
        chk("a_rst_eop",   eop_a,  0);
        chk("a_rst_src",   src_a,  0);
        chk("a_rst_busy",  busy_a, 0);
        chk("a_rst_cerr",  cerr_a, 0);
        chk("a_rst_cred",  cred_a, 4);

        // Round robin 0,1,2,3 then credit stall
        nxt(); reset_a = 1'b0; #1;
        chk("a_c0_pop", pop_a, 4'b0001); chk("a_c0_cred", cred_a, 4);
        nxt(); #1;
        chk("a_c1_pop", pop_a, 4'b0010); chk("a_c1_cred", cred_a, 3);
        nxt(); #1;
        chk("a_c2_pop", pop_a, 4'b0100); chk("a_c2_push", push_a, 1);
        chk("a_c2_src", src_a, 0); chk("a_c2_dout", dout_a, 16'h1111); chk("a_c2_eop", eop_a, 1);
        nxt(); #1;
        chk("a_c3_pop", pop_a, 4'b1000); chk("a_c3_push", push_a, 1);
        chk("a_c3_src", src_a, 1); chk("a_c3_dout", dout_a, 16'h2222); chk("a_c3_cred", cred_a, 1);
        nxt(); #1;
        chk("a_c4_pop", pop_a, 0); chk("a_c4_cred", cred_a, 0); chk("a_c4_busy", busy_a, 1);
        chk("a_c4_src", src_a, 2); chk("a_c4_dout", dout_a, 16'h3333);
        nxt(); #1;
        chk("a_c5_pop", pop_a, 0); chk("a_c5_src", src_a, 3); chk("a_c5_dout", dout_a, 16'h4444);
        nxt(); ret_a = 1'b1; #1;
        chk("a_c6_pop", pop_a, 0); chk("a_c6_push", push_a, 0);
        chk("a_c6_busy", busy_a, 0); chk("a_c6_cred", cred_a, 0);
        nxt(); ret_a = 1'b0; #1;
        chk("a_c7_cred", cred_a, 1); chk("a_c7_pop", pop_a, 4'b0001);
        nxt(); #1;
        chk("a_c8_pop", pop_a, 0); chk("a_c8_cred", cred_a, 0);
        nxt(); ret_a = 1'b1; #1;
        chk("a_c9_push", push_a, 1); chk("a_c9_src", src_a, 0); chk("a_c9_pop", pop_a, 0);
        nxt(); #1;
        chk("a_c10_cred", cred_a, 1); chk("a_c10_pop", pop_a, 4'b0010);
        nxt(); ret_a = 1'b0; #1;
        chk("a_c11_cred", cred_a, 1); chk("a_c11_pop", pop_a, 4'b0100); chk("a_c11_push", push_a, 0);
        nxt(); #1;
        chk("a_c12_push", push_a, 1); chk("a_c12_src", src_a, 1); chk("a_c12_cred", cred_a, 0);
        nxt(); #1;
        chk("a_c13_push", push_a, 1); chk("a_c13_dout", dout_a, 16'h3333);

        // Refill credits, then overflow
        nxt(); empty_a = 4'b1111; ret_a = 1'b1;
        repeat (4) nxt();
        #1;
        chk("a_full_cred", cred_a, 4); chk("a_full_cerr", cerr_a, 0);
        nxt(); ret_a = 1'b0; #1;
        chk("a_ovf_cred", cred_a, 4); chk("a_ovf_cerr", cerr_a, 1);
        nxt(); #1;
        chk("a_ovf_hold", cerr_a, 1);
        nxt(); reset_a = 1'b1;
        nxt(); #1;
        chk("a_rst2_cerr", cerr_a, 0); chk("a_rst2_cred", cred_a, 4);

        // PKT_MODE=0: head_eop=0 never locks
        nxt(); reset_a = 1'b0; empty_a = 4'b1001; heop_a = 4'b0000; #1;
        chk("a_p0_pop0", pop_a, 4'b0010);
        nxt(); #1;
        chk("a_p0_pop1", pop_a, 4'b0100);
        nxt(); #1;
        chk("a_p0_pop2", pop_a, 4'b0010); chk("a_p0_src", src_a, 1); chk("a_p0_eop", eop_a, 0);
        nxt(); empty_a = 4'b1111; #1;
        chk("a_p0_src2", src_a, 2); chk("a_p0_dout2", dout_a, 16'h3333);
        nxt(); nxt(); #1;
        chk("a_p0_busy", busy_a, 0);

        // Packet mode: 3-word packet on client 1, client 2 waiting
        nxt(); reset_b = 1'b0; empty_b = 4'b1001; heop_b = 4'b1101; #1;
        chk("b_d0_pop", pop_b, 4'b0010); chk("b_d0_busy", busy_b, 0);
        nxt(); #1;
        chk("b_d1_pop", pop_b, 4'b0010); chk("b_d1_busy", busy_b, 1);
        nxt(); heop_b = 4'b1111; #1;
        chk("b_d2_pop", pop_b, 4'b0010);
        nxt(); #1;
        chk("b_d3_pop", pop_b, 4'b0100); chk("b_d3_push", push_b, 1);
        chk("b_d3_src", src_b, 1); chk("b_d3_eop", eop_b, 0); chk("b_d3_cred", cred_b, 5);
        nxt(); empty_b = 4'b1111; #1;
        chk("b_d4_pop", pop_b, 0); chk("b_d4_eop", eop_b, 0);
        nxt(); #1;
        chk("b_d5_src", src_b, 1); chk("b_d5_eop", eop_b, 1);
        nxt(); #1;
        chk("b_d6_src", src_b, 2); chk("b_d6_eop", eop_b, 1); chk("b_d6_dout", dout_b, 16'h3333);
        nxt(); #1;
        chk("b_d7_push", push_b, 0); chk("b_d7_busy", busy_b, 0); chk("b_d7_cred", cred_b, 4);

        // Owner goes empty mid-packet: stall with lock held
        nxt(); reset_b = 1'b1;
        nxt(); reset_b = 1'b0; empty_b = 4'b1001; heop_b = 4'b1101; #1;
        chk("b_e0_pop", pop_b, 4'b0010);
        nxt(); #1;
        chk("b_e1_pop", pop_b, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            nxt(); empty_b = 4'b1011; #1;
            chk("b_stall_pop", pop_b, 0); chk("b_stall_busy", busy_b, 1);
        end
        nxt(); empty_b = 4'b1001; heop_b = 4'b1111; #1;
        chk("b_e5_pop", pop_b, 4'b0010);
        nxt(); #1;
        chk("b_e6_pop", pop_b, 4'b0100);

        // Reset one cycle after a pop drops the in-flight word
        nxt(); empty_b = 4'b1111; reset_b = 1'b1;
        nxt(); reset_b = 1'b0; empty_b = 4'b1110; #1;
        chk("b_f0_pop", pop_b, 4'b0001);
        nxt(); empty_b = 4'b1111; reset_b = 1'b1; #1;
        chk("b_f1_push", push_b, 0);
        nxt(); reset_b = 1'b0; #1;
        chk("b_f2_push", push_b, 0); chk("b_f2_cred", cred_b, 8); chk("b_f2_busy", busy_b, 0);
        nxt(); #1;
        chk("b_f3_push", push_b, 0);
        nxt(); #1;
        chk("b_f4_push", push_b, 0);

        // Fairness with 2-word packets on all clients, credits returned every cycle
        nxt(); reset_b = 1'b1;
        nxt(); reset_b = 1'b0; empty_b = 4'b0000; ret_b = 1'b1; wcnt = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) nxt();
            heop_b = wcnt;
            #1;
            g = (k / 2) % 4;
            chk("b_fair_pop", pop_b, 32'(4'b0001 << g));
            chk("b_fair_cred", cred_b, 8);
            if (k >= 3) begin
                pk = k - 3;
                chk("b_fair_push", push_b, 1);
                chk("b_fair_src", src_b, (pk / 2) % 4);
                chk("b_fair_eop", eop_b, pk % 2);
                chk("b_fair_dout", dout_b, words[(pk / 2) % 4]);
            end
            wcnt[g] = ~wcnt[g];
        end
        nxt(); ret_b = 1'b0; empty_b = 4'b1111; #1;
        chk("b_fair_cerr", cerr_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_router_ctrl.md
Name: pkt_router_ctrl

Overview:
- Next-generation multi-input router controller. Drains CLIENTS input FIFOs into one output FIFO.
- Integrates its own round-robin arbiter, so there is no external req/gnt loop.
- Replaces the output `full` level with credit-based flow control, so FIFO read latency (DELAY) can never overrun the output.
- Optional packet mode keeps a client's grant until its end-of-packet word is popped, so packets from different clients never interleave.

Parameters:
- CLIENTS, 4: number of input FIFOs; must be ≥2.
- WIDTH, 32: data word width.
- DELAY, 1: clocks from pop to input data valid; must be ≥1.
- CREDITS, 8: output FIFO depth, which is the initial credit count.
- PKT_MODE, 1: 1 = grant held for a whole packet; 0 = per-word round robin.
- IDW, $clog2(CLIENTS): width of the client index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- empty  in  CLIENTS  input FIFO empty flags.
- head_eop  in  CLIENTS  head word of FIFO i is end-of-packet; valid when !empty[i].
- pop  out  CLIENTS  one-hot or zero pop strobe to the input FIFOs.
- data_in  in  CLIENTS*WIDTH  flattened FIFO read data; client i occupies [i*WIDTH +: WIDTH].
- credit_return  in  1  pulse: the output FIFO consumer freed one slot.
- push  out  1  write strobe to the output FIFO.
- data_out  out  WIDTH  write data to the output FIFO.
- eop_out  out  1  end-of-packet flag accompanying data_out.
- src_id  out  IDW  source client of data_out.
- credits  out  $clog2(CREDITS+1)  current credit count.
- busy  out  1  high while a packet lock is held or any pop is still in flight.
- cred_err  out  1  sticky: a credit was returned while the count was already CREDITS.

Behaviour:
- Reset values:
  - pop=0, push=0, data_out=0, eop_out=0, src_id=0, busy=0, cred_err=0.
  - credits=CREDITS; round-robin pointer=0; lock cleared; all delay stages invalid.
- Pop eligibility: pop[i] is asserted in cycle t only if all of the following hold:
  - !empty[i];
  - credits>0;
  - client i wins arbitration (or holds the lock).
- At most one pop per cycle. pop is combinational from the registered state and the current inputs.
- Arbitration (no lock held):
  - Search starts at client ptr and proceeds ptr, ptr+1, … mod CLIENTS.
  - The first non-empty client wins.
  - On a pop by client g, ptr <= (g+1) mod CLIENTS.
- Packet lock (PKT_MODE=1):
  - A pop with head_eop[g]=0 sets lock=1 and owner=g.
  - While locked, only the owner may pop, even if it is empty; in that case pop=0 and the controller stalls with the lock held.
  - Popping the owner's word with head_eop=1 clears the lock in the next cycle; ptr advances past the owner.
  - A single-word packet (head_eop=1 on the first pop) never sets the lock.
- PKT_MODE=0: the lock is never set; head_eop is still carried through to eop_out.
- Credits:
  - A pop decrements credits.
  - credit_return increments credits.
  - Pop and credit_return in the same cycle leave credits unchanged.
  - credit_return while credits==CREDITS with no pop: credits stay saturated and cred_err is set until reset.
- Delay pipeline:
  - Stage k (k=1..DELAY) registers valid, idx and eop of the pop issued k cycles earlier.
  - push = valid[DELAY].
  - src_id = idx[DELAY].
  - eop_out = eop[DELAY].
  - data_out = data_in slice idx[DELAY] when push=1, otherwise 0 (combinational mux).
  - Latency from pop to push is exactly DELAY clocks. Throughput is one word per clock while credits last.
- busy = lock | OR of valid[1..DELAY].
- Reset mid-operation:
  - In-flight words are dropped, with no push.
  - The lock is cleared and credits are reloaded.
  - The system must reset the input and output FIFOs in the same cycle.

Test Plan:
- Reset with CLIENTS=4, DELAY=2, all FIFOs non-empty, PKT_MODE=0, single-word packets → pops in order 0,1,2,3,0. Each push follows its pop 2 clocks later with the matching src_id and data. All outputs read 0 during reset.
- Packet mode:
  - Stimulus: client 1 holds a 3-word packet (eop on word 3); client 2 is non-empty.
  - Required response: three consecutive pops to client 1, then client 2.
  - Variant: client 1 goes empty after word 2 for 3 cycles → pop=0 for those 3 cycles, client 2 is never popped, busy=1 throughout.
- Credits:
  - With CREDITS=4 and no credit_return → exactly 4 pops, then a stall and credits=0.
  - One credit_return pulse → exactly one further pop.
  - Pop and credit_return in the same cycle → credits unchanged.
- Overflow: credit_return pulse while credits=CREDITS → credits stays at CREDITS and cred_err=1, held until reset.
- Reset mid-flight, DELAY=3:
  - Stimulus: assert reset 1 cycle after a pop.
  - Required response: no push occurs, credits=CREDITS, busy=0 on the first cycle after reset.
- Fairness: all 4 clients continuously non-empty with 2-word packets, PKT_MODE=1 → grant sequence 0,0,1,1,2,2,3,3 repeating, with eop_out on every second push.
